// File: rtl/g_rrarb3_pkg.sv
// g_rrarb3_pkg -- shared definitions for the three-way round-robin arbiter.
// Holds the FSM state encoding, the requester index constants and a small
// one-hot to index helper used by the arbiter top.
package g_rrarb3_pkg;

  // Arbiter FSM states: IDLE means no grant is held, GRANT means exactly one is.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Requester indices; they also select bits in the 3-bit pending/grant vectors.
  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;

  // LAST resets to C so that the first rotation starts at A.
  localparam logic [1:0] LAST_RST = REQ_C;

  // Index of the asserted bit of a one-hot grant vector (A when all-zero).
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    if (oh[2]) begin
      idx = REQ_C;
    end else if (oh[1]) begin
      idx = REQ_B;
    end else begin
      idx = REQ_A;
    end
    return idx;
  endfunction

endpackage

// File: rtl/g_rrarb3_pick.sv
// g_rrarb3_pick -- combinational rotate-priority pick.
// Returns a one-hot vector selecting the first pending requester in the
// order LAST+1, LAST+2, LAST (mod 3), or all-zero when nothing is pending.
module g_rrarb3_pick
  import g_rrarb3_pkg::*;
(
  input  logic [2:0] pend_i,
  input  logic [1:0] last_i,
  output logic [2:0] grant_o
);

  // Priority search starting just after the last served requester.
  always_comb begin
    // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
    grant_o = 3'b000;
    case (last_i)
      REQ_A: begin
        if (pend_i[REQ_B])      grant_o = 3'b010;
        else if (pend_i[REQ_C]) grant_o = 3'b100;
        else if (pend_i[REQ_A]) grant_o = 3'b001;
      end
      REQ_B: begin
        if (pend_i[REQ_C])      grant_o = 3'b100;
        else if (pend_i[REQ_A]) grant_o = 3'b001;
        else if (pend_i[REQ_B]) grant_o = 3'b010;
      end
      default: begin
        if (pend_i[REQ_A])      grant_o = 3'b001;
        else if (pend_i[REQ_B]) grant_o = 3'b010;
        else if (pend_i[REQ_C]) grant_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/g_rrarb3.sv
// g_rrarb3 -- three-requester round-robin arbiter with registered grants.
// Requests AN/BN/CN are active-low; grants YA/YB/YC and BUSY are active-high.
// A holder keeps its grant until it releases; on release the grant moves
// straight to the next pending requester with no idle bubble.
// Optional feature: define G_RRARB3_TIMEOUT_EN to add a hold counter that
// forces rotation after HOLD_MAX cycles when another requester is waiting.
module g_rrarb3
  import g_rrarb3_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 8
) (
  input  logic CK,
  input  logic RN,
  input  logic AN,
  input  logic BN,
  input  logic CN,
  output logic YA,
  output logic YB,
  output logic YC,
  output logic BUSY
);

  state_e     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic       busy_q, busy_d;

  logic [2:0] pend;
  logic [2:0] pend_others;
  logic [1:0] holder_idx;
  logic       held;
  logic       expire;
  logic       rotate;
  logic [2:0] pick_pend;
  logic [1:0] pick_last;
  logic [2:0] pick_grant;

  assign pend        = ~{CN, BN, AN};
  assign pend_others = pend & ~grant_q;
  assign holder_idx  = onehot_to_idx(grant_q);
  assign held        = |(pend & grant_q);

`ifdef G_RRARB3_TIMEOUT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  // Timeout only revokes when someone else is actually waiting.
  assign expire = (cnt_q == CW'(HOLD_MAX)) && (|pend_others);

  // Hold counter: cleared on every new grant, saturating at HOLD_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_IDLE) || rotate) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(HOLD_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Hold counter register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [31:0] unused_cfg;

  // Without the timeout a grant is only ever given up by release.
  assign expire     = 1'b0;
  assign unused_cfg = 32'(HOLD_MAX) ^ 32'(CW);
`endif

  // A holder leaves on release or on timeout expiry.
  assign rotate = (state_q == ST_GRANT) && (!held || expire);

  // From IDLE search from LAST; on rotation search after the holder, excluding it.
  assign pick_pend = (state_q == ST_IDLE) ? pend   : pend_others;
  assign pick_last = (state_q == ST_IDLE) ? last_q : holder_idx;

  g_rrarb3_pick u_pick (
    .pend_i  (pick_pend),
    .last_i  (pick_last),
    .grant_o (pick_grant)
  );

  // FSM state register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
    end
  end

  // FSM next state: enter GRANT on any request, leave only when nobody is left.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|pend) state_d = ST_GRANT;
      ST_GRANT: if (rotate && !(|pend_others)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: next grant vector, LAST update and BUSY.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        grant_d = pick_grant;
      end
      ST_GRANT: begin
        if (rotate) begin
          grant_d = pick_grant;
          last_d  = holder_idx;
        end
      end
      default: begin
        grant_d = 3'b000;
      end
    endcase
    busy_d = |grant_d;
  end

  // Grant, LAST and BUSY registers; reset drops any grant immediately.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      grant_q <= 3'b000;
      last_q  <= LAST_RST;
      busy_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign YA   = grant_q[REQ_A];
  assign YB   = grant_q[REQ_B];
  assign YC   = grant_q[REQ_C];
  assign BUSY = busy_q;

endmodule
